decode_queue: RTL and testbench

DECODE_QUEUE -- requirements
Module: decode_queue

---
 rtl/decode_pkg.sv | 59 +++++
 rtl/decode_fifo.sv | 74 +++++++
 rtl/decode_queue.sv | 69 ++++++
 tb/tb_decode_queue.sv | 372 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/decode_pkg.sv
// Shared decode definitions: opcode constants, NOP bubble, format encoding,
// and helpers to classify an instruction and extract its immediate.
package decode_pkg;

    localparam logic [31:0] NOP_INST   = 32'h0000_0013;

    localparam logic [6:0]  OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0]  OPC_LOAD   = 7'b0000011;
    localparam logic [6:0]  OPC_JALR   = 7'b1100111;
    localparam logic [6:0]  OPC_SYSTEM = 7'b1110011;
    localparam logic [6:0]  OPC_STORE  = 7'b0100011;
    localparam logic [6:0]  OPC_BRANCH = 7'b1100011;
    localparam logic [6:0]  OPC_LUI    = 7'b0110111;
    localparam logic [6:0]  OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0]  OPC_JAL    = 7'b1101111;

    typedef enum logic [2:0] {
        FMT_R = 3'd0,
        FMT_I = 3'd1,
        FMT_S = 3'd2,
        FMT_B = 3'd3,
        FMT_U = 3'd4,
        FMT_J = 3'd5
    } fmt_e;

    function automatic fmt_e get_fmt(input logic [6:0] opc);
        fmt_e f;
        case (opc)
            OPC_OP_IMM, OPC_LOAD,
            OPC_JALR, OPC_SYSTEM: f = FMT_I;
            OPC_STORE:            f = FMT_S;
            OPC_BRANCH:           f = FMT_B;
            OPC_LUI, OPC_AUIPC:   f = FMT_U;
            OPC_JAL:              f = FMT_J;
            default:              f = FMT_R;
        endcase
        return f;
    endfunction

    function automatic logic [31:0] get_imm(
        input logic [31:0] inst,
        input fmt_e        fmt
    );
        logic [31:0] imm;
        case (fmt)
            FMT_I: imm = {{20{inst[31]}}, inst[31:20]};
            FMT_S: imm = {{20{inst[31]}}, inst[31:25],
                          inst[11:7]};
            FMT_B: imm = {{20{inst[31]}}, inst[7],
                          inst[30:25], inst[11:8], 1'b0};
            FMT_U: imm = {inst[31:12], 12'b0};
            FMT_J: imm = {{12{inst[31]}}, inst[19:12],
                          inst[20], inst[30:21], 1'b0};
            default: imm = 32'b0;
        endcase
        return imm;
    endfunction

endpackage

// File: rtl/decode_fifo.sv
// Circular FIFO of {PC, INST} entries between fetch and decode.
// Ports: CLK/RST, i_flush, i_hold (stall), push side, head entry, occupancy.
module decode_fifo
    import decode_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int XLEN  = 32
) (
    input  logic                    CLK,
    input  logic                    RST,
    input  logic                    i_flush,
    input  logic                    i_hold,
    input  logic                    i_push_valid,
    input  logic [XLEN-1:0]         i_pc,
    input  logic [31:0]             i_inst,
    output logic                    o_ready,
    output logic                    o_valid,
    output logic [XLEN-1:0]         o_pc,
    output logic [31:0]             o_inst,
    output logic [$clog2(DEPTH):0]  o_count
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL = (AW+1)'(DEPTH);

    logic [XLEN+31:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wptr;
    logic [AW-1:0]    r_rptr;
    logic [AW:0]      r_count;

    logic w_push;
    logic w_pop;

    // Ready looks only at registered occupancy, so a slot freed by a pop
    // this cycle is offered to fetch on the next one.
    assign o_ready = (r_count != FULL);
    assign o_valid = (r_count != '0);
    assign w_push  = i_push_valid && o_ready && !i_flush;
    assign w_pop   = o_valid && !i_hold && !i_flush;

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else if (i_flush) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_push) begin
                r_wptr <= r_wptr + AW'(1);
            end
            if (w_pop) begin
                r_rptr <= r_rptr + AW'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + (AW+1)'(1);
                2'b01:   r_count <= r_count - (AW+1)'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge CLK) begin
        if (w_push && !RST) begin
            r_mem[r_wptr] <= {i_pc, i_inst};
        end
    end

    assign {o_pc, o_inst} = r_mem[r_rptr];
    assign o_count        = r_count;

endmodule

// File: rtl/decode_queue.sv
// Fetch-to-decode queue with combinational field decode of the head entry.
// Ports: CLK/RST, FLUSH/STALL/MMU_WAIT, fetch PC/INST handshake,
// DECODE_* head fields (NOP bubble when empty), COUNT occupancy.
module decode_queue
    import decode_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int XLEN  = 32
) (
    input  logic                    CLK,
    input  logic                    RST,
    input  logic                    FLUSH,
    input  logic                    STALL,
    input  logic                    MMU_WAIT,
    input  logic                    IN_VALID,
    output logic                    IN_READY,
    input  logic [XLEN-1:0]         PC,
    input  logic [31:0]             INST,
    output logic                    DECODE_VALID,
    output logic [XLEN-1:0]         DECODE_PC,
    output logic [16:0]             DECODE_OPCODE,
    output logic [4:0]              DECODE_RD,
    output logic [4:0]              DECODE_RS1,
    output logic [4:0]              DECODE_RS2,
    output logic [31:0]             DECODE_RINST,
    output logic [31:0]             DECODE_IMM,
    output logic [2:0]              DECODE_FMT,
    output logic [$clog2(DEPTH):0]  COUNT
);

    logic            w_valid;
    logic [XLEN-1:0] w_head_pc;
    logic [31:0]     w_head_inst;
    logic [31:0]     w_inst;
    fmt_e            w_fmt;

    decode_fifo #(
        .DEPTH (DEPTH),
        .XLEN  (XLEN)
    ) u_fifo (
        .CLK          (CLK),
        .RST          (RST),
        .i_flush      (FLUSH),
        .i_hold       (STALL || MMU_WAIT),
        .i_push_valid (IN_VALID),
        .i_pc         (PC),
        .i_inst       (INST),
        .o_ready      (IN_READY),
        .o_valid      (w_valid),
        .o_pc         (w_head_pc),
        .o_inst       (w_head_inst),
        .o_count      (COUNT)
    );

    // An empty queue presents a NOP at PC 0 so decode sees a clean bubble.
    assign w_inst    = w_valid ? w_head_inst : NOP_INST;
    assign w_fmt     = get_fmt(w_inst[6:0]);

    assign DECODE_VALID  = w_valid;
    assign DECODE_PC     = w_valid ? w_head_pc : '0;
    assign DECODE_RINST  = w_inst;
    assign DECODE_OPCODE = {w_inst[6:0], w_inst[14:12], w_inst[31:25]};
    assign DECODE_RD     = w_inst[11:7];
    assign DECODE_RS1    = w_inst[19:15];
    assign DECODE_RS2    = w_inst[24:20];
    assign DECODE_IMM    = get_imm(w_inst, w_fmt);
    assign DECODE_FMT    = w_fmt;

endmodule

// File: tb/tb_decode_queue.sv
// Scenario bench for decode_queue with a scoreboard of queued entries.
module tb_decode_queue;

    localparam int DEPTH = 4;
    localparam int XLEN  = 32;
    localparam logic [31:0] NOP = 32'h0000_0013;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst;
    } ent_t;

    logic        CLK = 1'b0;
    logic        RST = 1'b1;
    logic        FLUSH = 1'b0;
    logic        STALL = 1'b0;
    logic        MMU_WAIT = 1'b0;
    logic        IN_VALID = 1'b0;
    logic        IN_READY;
    logic [31:0] PC = '0;
    logic [31:0] INST = '0;
    logic        DECODE_VALID;
    logic [31:0] DECODE_PC;
    logic [16:0] DECODE_OPCODE;
    logic [4:0]  DECODE_RD;
    logic [4:0]  DECODE_RS1;
    logic [4:0]  DECODE_RS2;
    logic [31:0] DECODE_RINST;
    logic [31:0] DECODE_IMM;
    logic [2:0]  DECODE_FMT;
    logic [2:0]  COUNT;

    int   vectors = 0;
    int   miscompares = 0;
    ent_t sb[$];

    decode_queue #(
        .DEPTH (DEPTH),
        .XLEN  (XLEN)
    ) dut (
        .CLK           (CLK),
        .RST           (RST),
        .FLUSH         (FLUSH),
        .STALL         (STALL),
        .MMU_WAIT      (MMU_WAIT),
        .IN_VALID      (IN_VALID),
        .IN_READY      (IN_READY),
        .PC            (PC),
        .INST          (INST),
        .DECODE_VALID  (DECODE_VALID),
        .DECODE_PC     (DECODE_PC),
        .DECODE_OPCODE (DECODE_OPCODE),
        .DECODE_RD     (DECODE_RD),
        .DECODE_RS1    (DECODE_RS1),
        .DECODE_RS2    (DECODE_RS2),
        .DECODE_RINST  (DECODE_RINST),
        .DECODE_IMM    (DECODE_IMM),
        .DECODE_FMT    (DECODE_FMT),
        .COUNT         (COUNT)
    );

    always #5 CLK = ~CLK;

    function automatic logic [31:0] mk_inst(input int i);
        logic [31:0] v;
        v = 32'h0000_0013 | (32'(i & 31) << 7);
        return v;
    endfunction

    // Advance one clock and update the scoreboard from the inputs that
    // were presented before the edge.
    task automatic clk1();
        bit   push;
        bit   pop;
        ent_t e;
        e.pc  = PC;
        e.inst = INST;
        push = IN_VALID && (sb.size() < DEPTH) && !FLUSH && !RST;
        pop  = (sb.size() != 0) && !STALL && !MMU_WAIT && !FLUSH;
        @(posedge CLK);
        #1;
        if (RST || FLUSH) begin
            sb.delete();
        end else begin
            if (pop) void'(sb.pop_front());
            if (push) sb.push_back(e);
        end
    endtask

    task automatic test_reset();
        RST = 1'b1;
        clk1();
        clk1();
        RST = 1'b0;
        STALL = 1'b1;
        for (int i = 0; i < 2; i++) begin
            IN_VALID = 1'b1;
            PC = 32'h80 + 32'(4*i);
            INST = mk_inst(i);
            clk1();
        end
        RST = 1'b1;
        PC = 32'h90;
        clk1();
        RST = 1'b0;
        IN_VALID = 1'b0;
        STALL = 1'b0;
        vectors++;
        if (COUNT !== 3'd0 || IN_READY !== 1'b1 || DECODE_VALID !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_state: count=%0d ready=%b valid=%b, want 0/1/0",
                     COUNT, IN_READY, DECODE_VALID);
        end
        vectors++;
        if (DECODE_PC !== 32'h0 || DECODE_RINST !== NOP || DECODE_RD !== 5'd0 ||
            DECODE_RS1 !== 5'd0 || DECODE_RS2 !== 5'd0 ||
            DECODE_IMM !== 32'h0 || DECODE_FMT !== 3'd1) begin
            miscompares++;
            $display("FAIL reset_bubble: pc=%h inst=%h rd=%0d imm=%h fmt=%0d, want 0/%h/0/0/1",
                     DECODE_PC, DECODE_RINST, DECODE_RD, DECODE_IMM, DECODE_FMT, NOP);
        end
    endtask

    task automatic test_basic();
        IN_VALID = 1'b1;
        PC = 32'h100;
        INST = 32'h0050_0093;
        clk1();
        IN_VALID = 1'b0;
        vectors++;
        if (DECODE_VALID !== 1'b1 || DECODE_PC !== sb[0].pc ||
            DECODE_RINST !== sb[0].inst) begin
            miscompares++;
            $display("FAIL basic_head: valid=%b pc=%h inst=%h, want 1/%h/%h",
                     DECODE_VALID, DECODE_PC, DECODE_RINST, sb[0].pc, sb[0].inst);
        end
        vectors++;
        if (DECODE_RD !== 5'd1 || DECODE_RS1 !== 5'd0 ||
            DECODE_IMM !== 32'd5 || DECODE_FMT !== 3'd1 ||
            DECODE_OPCODE !== {7'b0010011, 3'b000, 7'b0000000}) begin
            miscompares++;
            $display("FAIL basic_fields: rd=%0d rs1=%0d imm=%h fmt=%0d opc=%h, want 1/0/5/1/04c00",
                     DECODE_RD, DECODE_RS1, DECODE_IMM, DECODE_FMT, DECODE_OPCODE);
        end
        clk1();
        vectors++;
        if (DECODE_VALID !== 1'b0 || DECODE_PC !== 32'h0 ||
            DECODE_RINST !== NOP || DECODE_IMM !== 32'h0 || DECODE_RD !== 5'd0) begin
            miscompares++;
            $display("FAIL basic_bubble: valid=%b pc=%h inst=%h imm=%h, want 0/0/%h/0",
                     DECODE_VALID, DECODE_PC, DECODE_RINST, DECODE_IMM, NOP);
        end
    endtask

    task automatic test_fill_stall();
        STALL = 1'b1;
        for (int i = 0; i < 5; i++) begin
            IN_VALID = 1'b1;
            PC = 32'h200 + 32'(4*i);
            INST = mk_inst(i + 1);
            vectors++;
            if (IN_READY !== (i < DEPTH)) begin
                miscompares++;
                $display("FAIL fill_ready[%0d]: got %b want %b", i, IN_READY, i < DEPTH);
            end
            clk1();
        end
        IN_VALID = 1'b0;
        vectors++;
        if (COUNT !== 3'd4 || IN_READY !== 1'b0) begin
            miscompares++;
            $display("FAIL fill_full: count=%0d ready=%b, want 4/0", COUNT, IN_READY);
        end
        STALL = 1'b0;
        for (int i = 0; i < 4; i++) begin
            vectors++;
            if (DECODE_VALID !== 1'b1 || sb.size() == 0 ||
                DECODE_PC !== 32'h200 + 32'(4*i) || DECODE_RINST !== sb[0].inst) begin
                miscompares++;
                $display("FAIL drain[%0d]: valid=%b pc=%h, want 1/%h",
                         i, DECODE_VALID, DECODE_PC, 32'h200 + 32'(4*i));
            end
            clk1();
        end
        vectors++;
        if (DECODE_VALID !== 1'b0 || COUNT !== 3'd0) begin
            miscompares++;
            $display("FAIL drain_empty: valid=%b count=%0d, want 0/0", DECODE_VALID, COUNT);
        end
    endtask

    task automatic test_full_pop();
        STALL = 1'b1;
        for (int i = 0; i < 4; i++) begin
            IN_VALID = 1'b1;
            PC = 32'h300 + 32'(4*i);
            INST = mk_inst(i + 8);
            clk1();
        end
        STALL = 1'b0;
        PC = 32'h310;
        INST = mk_inst(12);
        vectors++;
        if (IN_READY !== 1'b0 || DECODE_PC !== 32'h300) begin
            miscompares++;
            $display("FAIL fullpop_pre: ready=%b pc=%h, want 0/300", IN_READY, DECODE_PC);
        end
        clk1();
        vectors++;
        if (COUNT !== 3'd3 || IN_READY !== 1'b1) begin
            miscompares++;
            $display("FAIL fullpop_blocked: count=%0d ready=%b, want 3/1", COUNT, IN_READY);
        end
        STALL = 1'b1;
        clk1();
        IN_VALID = 1'b0;
        vectors++;
        if (COUNT !== 3'd4) begin
            miscompares++;
            $display("FAIL fullpop_accept: count=%0d want 4", COUNT);
        end
        STALL = 1'b0;
        for (int i = 0; i < 4; i++) begin
            vectors++;
            if (sb.size() == 0 || DECODE_VALID !== 1'b1 || DECODE_PC !== sb[0].pc ||
                DECODE_PC !== 32'h304 + 32'(4*i)) begin
                miscompares++;
                $display("FAIL fullpop_drain[%0d]: valid=%b pc=%h, want 1/%h",
                         i, DECODE_VALID, DECODE_PC, 32'h304 + 32'(4*i));
            end
            clk1();
        end
    endtask

    task automatic test_back_to_back();
        IN_VALID = 1'b1;
        PC = 32'h500;
        INST = mk_inst(20);
        clk1();
        for (int i = 1; i < 5; i++) begin
            PC = 32'h500 + 32'(4*i);
            INST = mk_inst(20 + i);
            vectors++;
            if (COUNT !== 3'd1 || DECODE_PC !== 32'h500 + 32'(4*(i-1))) begin
                miscompares++;
                $display("FAIL b2b[%0d]: count=%0d pc=%h, want 1/%h",
                         i, COUNT, DECODE_PC, 32'h500 + 32'(4*(i-1)));
            end
            clk1();
        end
        IN_VALID = 1'b0;
        clk1();
        vectors++;
        if (COUNT !== 3'd0 || DECODE_VALID !== 1'b0) begin
            miscompares++;
            $display("FAIL b2b_end: count=%0d valid=%b, want 0/0", COUNT, DECODE_VALID);
        end
    endtask

    task automatic test_wrap_mmu();
        int sent = 0;
        int got  = 0;
        int cyc  = 0;
        while (got < 6 && cyc < 60) begin
            IN_VALID = (sent < 6);
            PC = 32'h400 + 32'(4*sent);
            INST = mk_inst(sent + 3);
            MMU_WAIT = (cyc % 3 == 1);
            vectors++;
            if (IN_READY !== (sb.size() < DEPTH) || COUNT !== 3'(sb.size())) begin
                miscompares++;
                $display("FAIL wrap_state[%0d]: ready=%b count=%0d, want %b/%0d",
                         cyc, IN_READY, COUNT, sb.size() < DEPTH, sb.size());
            end
            if (sb.size() != 0 && !MMU_WAIT) begin
                vectors++;
                if (DECODE_VALID !== 1'b1 || DECODE_PC !== 32'h400 + 32'(4*got) ||
                    DECODE_RINST !== sb[0].inst) begin
                    miscompares++;
                    $display("FAIL wrap_order[%0d]: valid=%b pc=%h, want 1/%h",
                             got, DECODE_VALID, DECODE_PC, 32'h400 + 32'(4*got));
                end
                got++;
            end
            if (IN_VALID && sb.size() < DEPTH) sent++;
            clk1();
            cyc++;
        end
        IN_VALID = 1'b0;
        MMU_WAIT = 1'b0;
        vectors++;
        if (got != 6) begin
            miscompares++;
            $display("FAIL wrap_timeout: drained %0d want 6", got);
        end
    endtask

    task automatic test_flush();
        STALL = 1'b1;
        for (int i = 0; i < 3; i++) begin
            IN_VALID = 1'b1;
            PC = 32'h600 + 32'(4*i);
            INST = mk_inst(i + 10);
            clk1();
        end
        vectors++;
        if (COUNT !== 3'd3) begin
            miscompares++;
            $display("FAIL flush_pre: count=%0d want 3", COUNT);
        end
        FLUSH = 1'b1;
        PC = 32'h6F0;
        INST = mk_inst(30);
        clk1();
        FLUSH = 1'b0;
        IN_VALID = 1'b0;
        STALL = 1'b0;
        vectors++;
        if (COUNT !== 3'd0 || DECODE_VALID !== 1'b0 || DECODE_PC !== 32'h0) begin
            miscompares++;
            $display("FAIL flush_empty: count=%0d valid=%b pc=%h, want 0/0/0",
                     COUNT, DECODE_VALID, DECODE_PC);
        end
        clk1();
        vectors++;
        if (DECODE_VALID !== 1'b0 || COUNT !== 3'd0) begin
            miscompares++;
            $display("FAIL flush_noenq: valid=%b count=%0d, want 0/0", DECODE_VALID, COUNT);
        end
    endtask

    task automatic test_imm();
        logic [31:0] insts [6];
        logic [31:0] imms  [6];
        logic [2:0]  fmts  [6];
        insts = '{32'hFE00_0EE3, 32'h8000_00EF, 32'h1234_5037,
                  32'h0020_A423, 32'h0020_81B3, 32'hFFF0_0093};
        imms  = '{32'hFFFF_FFFC, 32'hFFF0_0000, 32'h1234_5000,
                  32'h0000_0008, 32'h0000_0000, 32'hFFFF_FFFF};
        fmts  = '{3'd3, 3'd5, 3'd4, 3'd2, 3'd0, 3'd1};
        for (int i = 0; i < 6; i++) begin
            IN_VALID = 1'b1;
            PC = 32'h700 + 32'(4*i);
            INST = insts[i];
            clk1();
            IN_VALID = 1'b0;
            vectors++;
            if (sb.size() == 0 || DECODE_RINST !== sb[0].inst ||
                DECODE_FMT !== fmts[i] || DECODE_IMM !== imms[i]) begin
                miscompares++;
                $display("FAIL imm[%0d]: inst=%h fmt=%0d imm=%h, want %h/%0d/%h",
                         i, DECODE_RINST, DECODE_FMT, DECODE_IMM,
                         insts[i], fmts[i], imms[i]);
            end
            clk1();
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_fill_stall();
        test_full_pop();
        test_back_to_back();
        test_wrap_mmu();
        test_flush();
        test_imm();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
